// File: rtl/apb_master.sv
// Single-outstanding APB master: turns a valid/ready command into a SETUP/ACCESS
// transfer and returns a one-cycle response, with an optional wait-state timeout.
module apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslverr
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_done;
  logic               w_abort;
  logic               w_tmo_hit;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [ADDR_W-1:0]  r_paddr;
  logic               r_pwrite;
  logic [DATA_W-1:0]  r_pwdata;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_rsp_timeout;

  assign w_tmo_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        // A ready slave on the timeout edge is a normal completion.
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_wait_cnt    <= '0;
      r_paddr       <= '0;
      r_pwrite      <= 1'b0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_rsp_valid <= w_done | w_abort;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
      end
      if (r_state != S_ACCESS) r_wait_cnt <= '0;
      else if (!pready)        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_done) begin
        r_rsp_err     <= pslverr;
        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_err     <= 1'b1;
        r_rsp_rdata   <= '0;
        r_rsp_timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready   = (r_state == S_IDLE) && presetn;
  assign psel        = (r_state != S_IDLE);
  assign penable     = (r_state == S_ACCESS);
  assign paddr       = r_paddr;
  assign pwrite      = r_pwrite;
  assign pwdata      = r_pwdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4): reset, waits, errors, timeout and
// back-to-back traffic with a mid-transfer reset.
module tb_apb_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    presetn = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h55; cmd_wdata = 32'h66;
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    cyc(); cyc();
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 0", cmd_ready); end
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL reset_psel_penable got %b%b exp 00", psel, penable); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (paddr !== 32'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_apb_fields got %h %h %b exp 0", paddr, pwdata, pwrite); end
    n_checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_fields got %h %b %b exp 0", rsp_rdata, rsp_err, rsp_timeout); end
    cmd_valid = 1'b0;
    presetn = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", cmd_ready); end
    cyc();
  endtask

  task automatic test_zero_wait_write();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h12345678;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5A5A5;
    cyc();  // E0 accept
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF; cmd_wdata = 32'h0;
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0) begin n_fail++; $display("FAIL zw_setup got psel=%b penable=%b exp 1 0", psel, penable); end
    n_checks++; if (paddr !== 32'h10 || pwrite !== 1'b1 || pwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL zw_setup_fields got %h %b %h exp 10 1 a5a5a5a5", paddr, pwrite, pwdata); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL zw_setup_ready got %b exp 0", cmd_ready); end
    cyc();  // E1
    n_checks++; if (psel !== 1'b1 || penable !== 1'b1 || pwdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL zw_access got %b %b %h exp 1 1 a5a5a5a5", psel, penable, pwdata); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zw_early_rsp got %b exp 0", rsp_valid); end
    cyc();  // E2 complete
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL zw_done_bus got %b%b exp 00", psel, penable); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL zw_rsp got v=%b e=%b d=%h t=%b exp 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, rsp_timeout); end
    n_checks++; if (cmd_ready !== 1'b1 || paddr !== 32'h10) begin n_fail++; $display("FAIL zw_idle got ready=%b paddr=%h exp 1 10", cmd_ready, paddr); end
    cyc();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zw_pulse_width got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_wait2();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24; cmd_wdata = 32'h77;
    cyc();  // E0
    cmd_valid = 1'b0; cmd_addr = 32'h0;
    cyc();  // E1 -> ACCESS
    for (int i = 0; i < 2; i++) begin
      n_checks++; if (penable !== 1'b1 || psel !== 1'b1 || paddr !== 32'h24 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rw_access_%0d got %b %b %h %b exp 1 1 24 0", i, psel, penable, paddr, rsp_valid); end
      cyc();  // E2, E3 with pready low
    end
    n_checks++; if (penable !== 1'b1 || paddr !== 32'h24 || pwrite !== 1'b0) begin n_fail++; $display("FAIL rw_access_2 got %b %h %b exp 1 24 0", penable, paddr, pwrite); end
    pready = 1'b1; prdata = 32'hDEADBEEF;
    cyc();  // E4 complete
    prdata = 32'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin n_fail++; $display("FAIL rw_rsp got v=%b d=%h e=%b exp 1 deadbeef 0", rsp_valid, rsp_rdata, rsp_err); end
    n_checks++; if (psel !== 1'b0) begin n_fail++; $display("FAIL rw_done_psel got %b exp 0", psel); end
    cyc();
    n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_hold got v=%b d=%h exp 0 deadbeef", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_slave_error();
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFEF00D;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
    cyc();
    cmd_valid = 1'b0;
    cyc(); cyc();
    pslverr = 1'b0; prdata = 32'h0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b0) begin n_fail++; $display("FAIL se_rsp got v=%b e=%b t=%b exp 1 1 0", rsp_valid, rsp_err, rsp_timeout); end
    n_checks++; if (rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL se_rdata got %h exp cafef00d", rsp_rdata); end
    cyc();
  endtask

  task automatic test_timeout();
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hFFFFFFFF;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40;
    cyc();  // E0
    cmd_valid = 1'b0;
    cyc();  // E1 -> ACCESS
    for (int i = 0; i < 3; i++) begin
      cyc();  // ACCESS edges 1..3 with pready low
      n_checks++; if (penable !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait_%0d got penable=%b v=%b exp 1 0", i, penable, rsp_valid); end
    end
    cyc();  // 4th ACCESS edge -> abort
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0) begin n_fail++; $display("FAIL to_abort_bus got %b%b exp 00", psel, penable); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL to_abort_rsp got v=%b e=%b t=%b d=%h exp 1 1 1 0", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    cyc();
    // Same again, but the slave becomes ready on the 4th ACCESS edge.
    prdata = 32'h5A5A0001;
    cmd_valid = 1'b1; cmd_addr = 32'h44;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc(); cyc(); cyc();
    n_checks++; if (penable !== 1'b1) begin n_fail++; $display("FAIL to_race_wait got %b exp 1", penable); end
    pready = 1'b1;
    cyc();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h5A5A0001) begin n_fail++; $display("FAIL to_race_rsp got v=%b e=%b t=%b d=%h exp 1 0 0 5a5a0001", rsp_valid, rsp_err, rsp_timeout, rsp_rdata); end
    prdata = 32'h0;
    cyc();
  endtask

  task automatic test_back_to_back();
    pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h100; cmd_wdata = 32'hB0;
    cyc();  // E0 accept 0x100
    cmd_addr = 32'h104; cmd_wdata = 32'hB4;
    n_checks++; if (paddr !== 32'h100 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_first got %h ready=%b exp 100 0", paddr, cmd_ready); end
    cyc();  // E1
    n_checks++; if (cmd_ready !== 1'b0 || paddr !== 32'h100) begin n_fail++; $display("FAIL b2b_stall got ready=%b paddr=%h exp 0 100", cmd_ready, paddr); end
    cyc();  // E2 complete
    n_checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || paddr !== 32'h100) begin n_fail++; $display("FAIL b2b_done1 got v=%b ready=%b paddr=%h exp 1 1 100", rsp_valid, cmd_ready, paddr); end
    cyc();  // E3 accept 0x104
    cmd_addr = 32'h108; cmd_wdata = 32'hB8;
    n_checks++; if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h104 || pwdata !== 32'hB4) begin n_fail++; $display("FAIL b2b_second got %b %b %h %h exp 1 0 104 b4", psel, penable, paddr, pwdata); end
    cyc();  // E4 ACCESS
    presetn = 1'b0;
    #1;
    n_checks++; if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_async_rst got %b %b %h %b exp 0 0 0 0", psel, penable, paddr, cmd_ready); end
    cyc();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_rst_rsp got %b exp 0", rsp_valid); end
    presetn = 1'b1;
    #1;
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_release got ready=%b v=%b exp 1 0", cmd_ready, rsp_valid); end
    cyc();  // accept 0x108
    cmd_valid = 1'b0;
    n_checks++; if (psel !== 1'b1 || paddr !== 32'h108 || pwdata !== 32'hB8 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after_rst got %b %h %h v=%b exp 1 108 b8 0", psel, paddr, pwdata, rsp_valid); end
    cyc(); cyc();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_final_rsp got v=%b e=%b exp 1 0", rsp_valid, rsp_err); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_zero_wait_write();
    test_read_wait2();
    test_slave_error();
    test_timeout();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB master bridge that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns a one-cycle response pulse. It sits directly upstream of the APB bus interface (paddr/psel/penable/pwrite/pwdata/pready/prdata/pslverr) and drives the slave side through it. It includes a programmable wait-state timeout, so a hung slave cannot stall the command stream indefinitely.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- pclk  in  1  clock
- presetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted on edge where valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data (0 for writes/timeouts)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  completion was a timeout abort
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- pready  in  1  APB slave ready
- prdata  in  DATA_W  APB read data
- pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready=1 (forced 0 while presetn low). On edge with cmd_valid high, latch cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata; go to SETUP.
- SETUP: psel=1, penable=0; go unconditionally to ACCESS on the next edge.
- ACCESS: psel=1, penable=1. On each edge:
  - pready=1: complete. Go to IDLE; rsp_valid=1 next cycle; rsp_err=pslverr; rsp_rdata=prdata for reads, 0 for writes; rsp_timeout=0.
  - pready=0, TIMEOUT≠0, wait count = TIMEOUT-1: abort. Go to IDLE; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Otherwise: increment wait count and stay in ACCESS.
- Wait counter: width clog2(TIMEOUT+1), cleared on entry to ACCESS.
- pready high on the timeout edge wins; it is a normal completion.
- paddr, pwrite, pwdata held stable from SETUP through the end of ACCESS. They keep their last values in IDLE and change only on command accept.
- cmd_ready is 0 in SETUP and ACCESS. Commands presented then are stalled, not dropped.
- pslverr and prdata are sampled only on the completing edge.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, state=IDLE, wait count=0.
- Accept at edge E0 gives SETUP after E0 and ACCESS after E1. penable rises exactly one cycle after psel rises.
- Zero-wait slave (pready=1 at E2): psel/penable low and rsp_valid high after E2. Earliest next accept is E3, giving a throughput of one transfer per 3 cycles.
- Each wait state adds one cycle.
- With TIMEOUT=T, abort happens at the T-th ACCESS edge with pready low.
- rsp_valid is high for exactly one cycle. rsp_rdata/rsp_err/rsp_timeout are valid only while rsp_valid=1 and hold their values until the next completion.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously). The in-flight command is discarded and no response is emitted.
- psel and penable always deassert on the same edge.

## Test plan
- Reset: hold presetn low with cmd_valid=1 → cmd_ready=0, psel=penable=rsp_valid=0, paddr=pwdata=0.
- Zero-wait write (addr 0x10, data 0xA5A5A5A5, pready tied 1) → psel=1 one cycle before penable=1; pwdata=0xA5A5A5A5 stable; rsp_valid pulse 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read with 2 wait states (prdata=0xDEADBEEF on the ready edge) → ACCESS lasts 3 cycles; rsp_rdata=0xDEADBEEF; paddr stable throughout.
- Slave error: pready=1, pslverr=1 on a read → rsp_err=1, rsp_timeout=0.
- Timeout with TIMEOUT=4 and pready stuck 0 → abort after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, psel=0. Repeat with pready rising on the 4th edge → normal completion, rsp_timeout=0.
- Back-to-back commands with cmd_valid held high, plus presetn pulsed low during ACCESS → one accept every 3 cycles; the reset aborts the transfer with no rsp_valid, and the next command is accepted after reset release.
